// File: rtl/vend_sequencer.sv
// vend_sequencer: vending machine transaction controller.
// Latches a selection price, waits for enough payment, plans change greedily
// from the coin inventory, dispenses change one coin per valid/ready handshake,
// then vends or refunds and pulses m_rst to clear the coin receiver.
// Optional build macro VEND_TIMEOUT_EN: refund after TIMEOUT_CYC cycles in
// COLLECT with no change in payment_in.
module vend_sequencer #(
    parameter int PAY_W       = 5,
    parameter int CNT_W       = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             sel_valid,
    input  logic [PAY_W-1:0] sel_price,
    input  logic             cancel,
    input  logic [PAY_W-1:0] payment_in,
    input  logic [CNT_W-1:0] am_1,
    input  logic [CNT_W-1:0] am_5,
    input  logic [CNT_W-1:0] am_10,
    input  logic             disp_ready,
    output logic             disp_valid,
    output logic [1:0]       disp_coin,
    output logic             enough_ch,
    output logic             vend,
    output logic             refund,
    output logic             m_rst,
    output logic             busy,
    output logic [2:0]       state
);

    // Common width for change arithmetic and coin counts
    localparam int WW = (PAY_W > CNT_W) ? PAY_W : CNT_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHECK   = 3'd2,
        S_CHANGE  = 3'd3,
        S_VEND    = 3'd4,
        S_REFUND  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t           st, st_nx;
    logic [PAY_W-1:0] price;
    logic [WW-1:0]    p10, p5, p1;       // coins still to dispense
    logic [PAY_W-1:0] chg;
    logic [WW-1:0]    q10, n10, r10, q5, n5, r5, n1, r1;
    logic             plan_ok;
    logic [WW+1:0]    remaining;
    logic             hs, last_coin;
    logic             timeout_hit;

    // Greedy change plan from the live payment; only consumed in CHECK
    always_comb begin
        chg     = payment_in - price;
        q10     = WW'(chg) / WW'(10);
        n10     = (q10 < WW'(am_10)) ? q10 : WW'(am_10);
        r10     = WW'(chg) - n10 * WW'(10);
        q5      = r10 / WW'(5);
        n5      = (q5 < WW'(am_5)) ? q5 : WW'(am_5);
        r5      = r10 - n5 * WW'(5);
        n1      = (r5 < WW'(am_1)) ? r5 : WW'(am_1);
        r1      = r5 - n1;
        plan_ok = (r1 == '0);
    end

    assign remaining = {2'b00, p10} + {2'b00, p5} + {2'b00, p1};
    assign hs        = disp_valid && disp_ready;
    assign last_coin = hs && (remaining == (WW+2)'(1));

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0]  tcnt;
    logic [PAY_W-1:0] pay_prev;

    // Idle counter: held at 0 outside COLLECT, restarts on any payment movement
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tcnt     <= '0;
            pay_prev <= '0;
        end else begin
            pay_prev <= payment_in;
            if (st != S_COLLECT || payment_in != pay_prev)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout_hit = (st == S_COLLECT) && (tcnt == TO_W'(TIMEOUT_CYC - 1));
`else
    // Without the feature COLLECT waits forever; the comparison is always false
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // State register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) st <= S_IDLE;
        else       st <= st_nx;
    end

    // Next-state and outputs; pulses are decoded straight from the state
    always_comb begin
        st_nx      = st;
        disp_valid = 1'b0;
        disp_coin  = 2'd0;
        enough_ch  = 1'b0;
        vend       = 1'b0;
        refund     = 1'b0;
        m_rst      = 1'b0;
        busy       = (st != S_IDLE);
        state      = st;
        case (st)
            S_IDLE:
                if (sel_valid) st_nx = S_COLLECT;
            S_COLLECT:
                // cancel beats sufficient payment, which beats timeout
                if (cancel)                   st_nx = S_REFUND;
                else if (payment_in >= price) st_nx = S_CHECK;
                else if (timeout_hit)         st_nx = S_REFUND;
            S_CHECK:
                if (!plan_ok)        st_nx = S_REFUND;
                else if (chg == '0)  st_nx = S_VEND;
                else                 st_nx = S_CHANGE;
            S_CHANGE: begin
                enough_ch  = 1'b1;
                disp_valid = (remaining != '0);
                if (p10 != '0)     disp_coin = 2'd2;
                else if (p5 != '0) disp_coin = 2'd1;
                else               disp_coin = 2'd0;
                if (remaining == '0 || last_coin) st_nx = S_VEND;
            end
            S_VEND: begin
                vend      = 1'b1;
                enough_ch = 1'b1;
                st_nx     = S_DONE;
            end
            S_REFUND: begin
                refund = 1'b1;
                st_nx  = S_DONE;
            end
            S_DONE: begin
                m_rst = 1'b1;
                st_nx = S_IDLE;
            end
            default: st_nx = S_IDLE;
        endcase
    end

    // Price latch: captured on selection, cleared when the transaction closes
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)                          price <= '0;
        else if (st == S_IDLE && sel_valid) price <= sel_price;
        else if (st == S_DONE)              price <= '0;
    end

    // Change plan: loaded on a good CHECK, one count consumed per handshake
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            p10 <= '0;
            p5  <= '0;
            p1  <= '0;
        end else if (st == S_CHECK && plan_ok) begin
            p10 <= n10;
            p5  <= n5;
            p1  <= n1;
        end else if (st == S_CHANGE && hs) begin
            if (p10 != '0)     p10 <= p10 - 1'b1;
            else if (p5 != '0) p5  <= p5 - 1'b1;
            else               p1  <= p1 - 1'b1;
        end else if (st == S_DONE) begin
            p10 <= '0;
            p5  <= '0;
            p1  <= '0;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer. Build with +define+VEND_TIMEOUT_EN to
// exercise the idle-timeout refund (TIMEOUT_CYC=8).
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       i_rst, sel_valid, cancel, disp_ready;
    logic [4:0] sel_price, payment_in;
    logic [5:0] am_1, am_5, am_10;
    logic       disp_valid, enough_ch, vend, refund, m_rst, busy;
    logic [1:0] disp_coin;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // per-transaction observations
    int n_hs, n_vend, n_ref, n_mrst, n_valid, ench_hi, ench_bad, first_hs, last_hs;
    int coins[$];

    vend_sequencer #(.PAY_W(5), .CNT_W(6), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .i_rst(i_rst), .sel_valid(sel_valid), .sel_price(sel_price),
        .cancel(cancel), .payment_in(payment_in), .am_1(am_1), .am_5(am_5),
        .am_10(am_10), .disp_ready(disp_ready), .disp_valid(disp_valid),
        .disp_coin(disp_coin), .enough_ch(enough_ch), .vend(vend),
        .refund(refund), .m_rst(m_rst), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select an item and confirm the move to COLLECT
    task automatic start(input int price, input int pay);
        sel_valid  = 1'b1;
        sel_price  = 5'(price);
        payment_in = 5'(pay);
        tick();
        sel_valid  = 1'b0;
        chk("enter_collect", state, 1);
    endtask

    // Run from the current state until m_rst, acting as the coin dispenser
    // with 'stall' ready-low cycles per coin
    task automatic run_txn(input int stall, input int budget);
        int  wcnt = 0;
        bit  pv = 0, pr = 0, done = 0;
        int  pc = 0;
        n_hs = 0; n_vend = 0; n_ref = 0; n_mrst = 0; n_valid = 0;
        ench_hi = 0; ench_bad = 0; first_hs = -1; last_hs = -1;
        coins.delete();
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (pv && !pr) begin
                chk("stall_valid", disp_valid, 1);
                chk("stall_coin", disp_coin, pc);
            end
            if (disp_valid) n_valid++;
            if (enough_ch)  ench_hi++;
            if (vend) begin
                n_vend++;
                if (!enough_ch) ench_bad++;
            end
            if (refund) n_ref++;
            if (m_rst) begin
                n_mrst++;
                done = 1;
            end
            disp_ready = 1'b0;
            if (disp_valid) begin
                wcnt++;
                if (wcnt > stall) disp_ready = 1'b1;
            end
            if (disp_valid && disp_ready) begin
                coins.push_back(int'(disp_coin));
                if (!enough_ch) ench_bad++;
                if (n_hs == 0) first_hs = c;
                last_hs = c;
                n_hs++;
                wcnt = 0;
            end
            pv = disp_valid;
            pr = disp_ready;
            pc = int'(disp_coin);
        end
        if (!done) chk("txn_budget", 0, 1);
        disp_ready = 1'b0;
        tick();
        chk("idle_after", state, 0);
    endtask

    initial begin
        int e3[3];
        i_rst = 1'b1; sel_valid = 1'b0; cancel = 1'b0; disp_ready = 1'b0;
        sel_price = '0; payment_in = '0; am_1 = '0; am_5 = '0; am_10 = '0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_outs", {disp_valid, enough_ch, vend, refund, m_rst, busy}, 0);
        i_rst = 1'b0;
        tick();
        chk("idle_state", state, 0);

        // price 7, pay 10: three 1-unit coins back to back
        am_1 = 6; am_5 = 2; am_10 = 1;
        start(7, 0);
        sel_valid = 1'b1; sel_price = 20;     // must be ignored in COLLECT
        tick();
        sel_valid = 1'b0;
        chk("t1_collect", state, 1);
        payment_in = 10;
        tick();
        chk("t1_check", state, 2);
        run_txn(0, 40);
        chk("t1_nhs", n_hs, 3);
        for (int i = 0; i < 3; i++)
            chk("t1_coin", (i < coins.size()) ? coins[i] : -1, 0);
        chk("t1_first_lat", first_hs, 0);
        chk("t1_consec", last_hs - first_hs, 2);
        chk("t1_vend", n_vend, 1);
        chk("t1_refund", n_ref, 0);
        chk("t1_mrst", n_mrst, 1);
        chk("t1_ench", ench_bad, 0);

        // price 3, pay 20, no 5s: remainder 5 -> refund
        am_1 = 2; am_5 = 0; am_10 = 1;
        start(3, 0);
        payment_in = 20;
        tick();
        chk("t2_check", state, 2);
        run_txn(0, 20);
        chk("t2_valid", n_valid, 0);
        chk("t2_refund", n_ref, 1);
        chk("t2_vend", n_vend, 0);
        chk("t2_ench", ench_hi, 0);
        chk("t2_mrst", n_mrst, 1);

        // price 4, pay 20: coins 10,5,1 with 4 stall cycles each
        am_1 = 1; am_5 = 1; am_10 = 1;
        start(4, 0);
        payment_in = 20;
        tick();
        chk("t3_check", state, 2);
        run_txn(4, 60);
        e3 = '{2, 1, 0};
        chk("t3_nhs", n_hs, 3);
        for (int i = 0; i < 3; i++)
            chk("t3_coin", (i < coins.size()) ? coins[i] : -1, e3[i]);
        chk("t3_first", first_hs, 4);
        chk("t3_vend", n_vend, 1);
        chk("t3_ench", ench_bad, 0);

        // cancel on the same cycle payment becomes sufficient
        start(5, 0);
        payment_in = 5;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t4_state", state, 5);
        chk("t4_refund", refund, 1);
        chk("t4_vend_now", vend, 0);
        run_txn(0, 10);
        chk("t4_vend", n_vend, 0);
        chk("t4_mrst", n_mrst, 1);

        // async reset while a coin is being offered
        am_1 = 1; am_5 = 1; am_10 = 1;
        start(5, 0);
        payment_in = 10;
        tick();
        tick();
        chk("t5_valid", disp_valid, 1);
        chk("t5_coin", disp_coin, 1);
        #3 i_rst = 1'b1;
        #1;
        chk("t5_rst_outs", {disp_valid, enough_ch, vend, refund, m_rst, busy}, 0);
        chk("t5_rst_state", state, 0);
        tick();
        i_rst = 1'b0;
        tick();
        // price 0 goes straight through CHECK to VEND
        start(0, 0);
        tick();
        chk("t5_check", state, 2);
        run_txn(0, 10);
        chk("t5_vend", n_vend, 1);
        chk("t5_nvalid", n_valid, 0);

`ifdef VEND_TIMEOUT_EN
        // payment frozen below price; one change restarts the idle count
        start(10, 8);
        repeat (5) tick();
        chk("t6_wait", state, 1);
        payment_in = 9;
        repeat (8) tick();
        chk("t6_pre", state, 1);
        tick();
        chk("t6_refund_state", state, 5);
        run_txn(0, 10);
        chk("t6_vend", n_vend, 0);
`else
        // no timeout: COLLECT waits until cancel
        start(10, 8);
        repeat (20) tick();
        chk("t6_wait", state, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t6_cancel", state, 5);
        run_txn(0, 10);
        chk("t6_vend", n_vend, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got 0 exp 1");
        $fatal(1);
    end

endmodule
